// File: rtl/stream_stats_pkg.sv
// Shared types and width helpers for the stream statistics block.
package stream_stats_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic int cnt_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int sum_w(input int data_w, input int max_len);
    return data_w + cnt_w(max_len);
  endfunction

endpackage

// File: rtl/stats_divider.sv
// Restoring divider: one quotient bit per cycle, SUM_W cycles per start.
module stats_divider #(
  parameter int SUM_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  input  logic [SUM_W-1:0] DIVIDEND,
  input  logic [CNT_W-1:0] DIVISOR,
  output logic [SUM_W-1:0] QUOT,
  output logic [CNT_W-1:0] REM
);

  localparam int IT_W = $clog2(SUM_W + 1);

  logic [SUM_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] dvs_q, dvs_d;
  logic [IT_W-1:0]  it_q, it_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W:0]   rem_sh;
  logic             ge;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    it_d   = it_q;
    busy_d = busy_q;
    done_d = 1'b0;
    rem_sh = {rem_q, quo_q[SUM_W-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    if (START) begin
      quo_d  = DIVIDEND;
      rem_d  = '0;
      dvs_d  = DIVISOR;
      it_d   = IT_W'(SUM_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d = {quo_q[SUM_W-2:0], ge};
      // true difference is below the divisor, so modular CNT_W math is exact
      rem_d = ge ? (rem_sh[CNT_W-1:0] - dvs_q)
                 : rem_sh[CNT_W-1:0];
      it_d  = it_q - 1'b1;
      if (it_q == IT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      it_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      it_q   <= it_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign QUOT = quo_q;
  assign REM  = rem_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: rtl/stream_stats.sv
// Per-frame max/min/average of an unsigned sample stream.
module stream_stats
  import stream_stats_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int MAX_LEN = 255,
  localparam int CNT_W   = cnt_w(MAX_LEN),
  localparam int SUM_W   = sum_w(DATA_W, MAX_LEN)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_LAST,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] MAX,
  output logic [DATA_W-1:0] MIN,
  output logic [DATA_W-1:0] QUOTIENT,
  output logic [CNT_W-1:0]  REMAINDER,
  output logic [CNT_W-1:0]  COUNT,
  output logic              OVERFLOW
);

  state_e            state_q, state_d;
  logic              rdy_q;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] rmax_q, rmax_d;
  logic [DATA_W-1:0] rmin_q, rmin_d;
  logic [DATA_W-1:0] rquo_q, rquo_d;
  logic [CNT_W-1:0]  rrem_q, rrem_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;

  logic              xfer;
  logic [CNT_W-1:0]  cnt_inc;
  logic              cnt_full;
  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [SUM_W-1:0]  div_quot;
  logic [CNT_W-1:0]  div_rem;
  logic              unused_div;

  // rdy_q keeps IN_READY low until the first edge after reset release
  assign IN_READY = rdy_q && (state_q == ST_ACCUM);
  assign xfer     = IN_VALID && IN_READY;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign cnt_full = (cnt_inc == CNT_W'(MAX_LEN));

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    min_d     = min_q;
    ovf_d     = ovf_q;
    rmax_d    = rmax_q;
    rmin_d    = rmin_q;
    rquo_d    = rquo_q;
    rrem_d    = rrem_q;
    rcnt_d    = rcnt_q;
    div_start = 1'b0;
    unique case (state_q)
      ST_ACCUM: begin
        if (xfer) begin
          sum_d = sum_q + {{CNT_W{1'b0}}, IN_DATA};
          cnt_d = cnt_inc;
          if (cnt_q == '0) begin
            max_d = IN_DATA;
            min_d = IN_DATA;
          end else begin
            if (IN_DATA > max_q) max_d = IN_DATA;
            if (IN_DATA < min_q) min_d = IN_DATA;
          end
          if (IN_LAST || cnt_full) begin
            state_d   = ST_DIVIDE;
            ovf_d     = !IN_LAST;
            div_start = 1'b1;
          end
        end
      end
      ST_DIVIDE: begin
        if (div_done) begin
          state_d = ST_DONE;
          rmax_d  = max_q;
          rmin_d  = min_q;
          rquo_d  = div_quot[DATA_W-1:0];
          rrem_d  = div_rem;
          rcnt_d  = cnt_q;
        end
      end
      ST_DONE: begin
        if (OUT_READY) begin
          state_d = ST_ACCUM;
          sum_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_ACCUM;
      rdy_q   <= 1'b0;
      sum_q   <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
      ovf_q   <= 1'b0;
      rmax_q  <= '0;
      rmin_q  <= '0;
      rquo_q  <= '0;
      rrem_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      min_q   <= min_d;
      ovf_q   <= ovf_d;
      rmax_q  <= rmax_d;
      rmin_q  <= rmin_d;
      rquo_q  <= rquo_d;
      rrem_q  <= rrem_d;
      rcnt_q  <= rcnt_d;
    end
  end

  stats_divider #(
    .SUM_W(SUM_W),
    .CNT_W(CNT_W)
  ) u_div (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (div_start),
    .BUSY     (div_busy),
    .DONE     (div_done),
    .DIVIDEND (sum_d),
    .DIVISOR  (cnt_d),
    .QUOT     (div_quot),
    .REM      (div_rem)
  );

  // average never exceeds MAX, so upper quotient bits are always zero
  assign unused_div = div_busy ^ (^div_quot[SUM_W-1:DATA_W]);

  assign OUT_VALID = (state_q == ST_DONE);
  assign MAX       = rmax_q;
  assign MIN       = rmin_q;
  assign QUOTIENT  = rquo_q;
  assign REMAINDER = rrem_q;
  assign COUNT     = rcnt_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_stream_stats.sv
// Directed bench for stream_stats: frame results, latency, hold, reset.
module tb_stream_stats;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] IN_DATA = '0;
  logic       IN_LAST = 1'b0;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [7:0] MAX, MIN, QUOTIENT;
  logic [7:0] REMAINDER, COUNT;
  logic       OVERFLOW;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_last = 0;
  int lat    = 0;

  stream_stats #(
    .DATA_W (8),
    .MAX_LEN(255)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_DATA  (IN_DATA),
    .IN_LAST  (IN_LAST),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .MAX      (MAX),
    .MIN      (MIN),
    .QUOTIENT (QUOTIENT),
    .REMAINDER(REMAINDER),
    .COUNT    (COUNT),
    .OVERFLOW (OVERFLOW)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    IN_VALID = 1'b1;
    IN_DATA  = d;
    IN_LAST  = l;
    while (!IN_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) chk("send_timeout", 32'(IN_READY), 1);
    @(negedge CLK);
    t_last   = cyc;
    IN_VALID = 1'b0;
    IN_DATA  = 8'hFF;
    IN_LAST  = 1'b1;
  endtask

  task automatic wait_out(input string f);
    int n = 0;
    while (!OUT_VALID && n < 200) begin
      @(negedge CLK);
      n++;
    end
    lat = cyc - t_last;
    chk({f, ".valid"}, 32'(OUT_VALID), 1);
  endtask

  task automatic chk_res(input string f,
                         input int mx, input int mn,
                         input int q, input int r,
                         input int c, input int ov);
    chk({f, ".max"}, 32'(MAX), mx);
    chk({f, ".min"}, 32'(MIN), mn);
    chk({f, ".quot"}, 32'(QUOTIENT), q);
    chk({f, ".rem"}, 32'(REMAINDER), r);
    chk({f, ".count"}, 32'(COUNT), c);
    chk({f, ".ovf"}, 32'(OVERFLOW), ov);
  endtask

  task automatic handshake();
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("rst.in_ready", 32'(IN_READY), 0);
    chk("rst.out_valid", 32'(OUT_VALID), 0);
    chk("rst.max", 32'(MAX), 0);
    chk("rst.quot", 32'(QUOTIENT), 0);
    chk("rst.count", 32'(COUNT), 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst.ready_after", 32'(IN_READY), 1);
  endtask

  initial begin
    int d4[4];
    d4 = '{10, 20, 30, 45};

    #1 RESET = 1'b1;
    @(negedge CLK);
    chk("init.in_ready", 32'(IN_READY), 0);
    chk("init.out_valid", 32'(OUT_VALID), 0);
    chk("init.count", 32'(COUNT), 0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("init.ready_after", 32'(IN_READY), 1);

    // frame A: back-to-back samples
    foreach (d4[i]) send(8'(d4[i]), i == 3);
    wait_out("A");
    chk("A.latency", 32'(lat), 17);
    chk_res("A", 45, 10, 26, 1, 4, 0);

    // held result while the consumer stalls; offered sample must be refused
    IN_VALID = 1'b1;
    IN_DATA  = 8'd99;
    IN_LAST  = 1'b1;
    repeat (20) @(negedge CLK);
    chk("hold.in_ready", 32'(IN_READY), 0);
    chk("hold.out_valid", 32'(OUT_VALID), 1);
    chk_res("hold", 45, 10, 26, 1, 4, 0);
    IN_VALID = 1'b0;
    handshake();
    chk("hs.out_valid", 32'(OUT_VALID), 0);
    chk("hs.in_ready", 32'(IN_READY), 1);
    chk("hs.max_hold", 32'(MAX), 45);

    // frame B: single sample
    send(8'd200, 1'b1);
    wait_out("B");
    chk_res("B", 200, 200, 200, 0, 1, 0);
    handshake();

    // frame C: MAX_LEN samples without LAST closes the frame with overflow
    for (int i = 0; i < 255; i++) send(8'd255, 1'b0);
    chk("C.ready_closed", 32'(IN_READY), 0);
    wait_out("C");
    chk_res("C", 255, 255, 255, 0, 255, 1);
    handshake();
    chk("C.ovf_cleared", 32'(OVERFLOW), 0);

    // frame E: LAST on the MAX_LEN-th sample is a normal close
    for (int i = 0; i < 254; i++) send(8'd1, 1'b0);
    send(8'd3, 1'b1);
    wait_out("E");
    chk_res("E", 3, 1, 1, 2, 255, 0);
    handshake();

    // partial frame discarded by reset
    send(8'd100, 1'b0);
    pulse_reset();
    send(8'd7, 1'b0);
    send(8'd9, 1'b1);
    wait_out("F");
    chk_res("F", 9, 7, 8, 0, 2, 0);
    handshake();

    // reset in the middle of a division
    send(8'd50, 1'b0);
    send(8'd60, 1'b1);
    repeat (5) @(negedge CLK);
    pulse_reset();
    send(8'd7, 1'b0);
    send(8'd9, 1'b1);
    wait_out("G");
    chk_res("G", 9, 7, 8, 0, 2, 0);
    handshake();

    // frame A again with random valid bubbles and junk on idle cycles
    foreach (d4[i]) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      send(8'(d4[i]), i == 3);
    end
    wait_out("D");
    chk("D.latency", 32'(lat), 17);
    chk_res("D", 45, 10, 26, 1, 4, 0);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
